// File: rtl/dht11_sched.sv
// DHT11 read scheduler: merges periodic poll and on-demand requests, enforces
// power-up and inter-read spacing, checks the frame checksum and retries failures.
module dht11_sched #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned POWERUP_MS = 1000,
    parameter int unsigned MIN_GAP_MS = 2000,
    parameter int unsigned POLL_MS    = 2000,
    parameter int unsigned TIMEOUT_MS = 50,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        poll_en,
    input  logic [1:0]  req,
    output logic [1:0]  ack,
    output logic        rd_start,
    input  logic        rd_done,
    input  logic        rd_err,
    input  logic [39:0] rd_data,
    output logic [15:0] humi,
    output logic [15:0] temp,
    output logic        data_valid,
    output logic        fail,
    output logic [7:0]  err_cnt,
    output logic        busy
);
    localparam int unsigned TICK_DIV = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
    localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [15:0] POWERUP_V = 16'(POWERUP_MS);
    localparam logic [15:0] MIN_GAP_V = 16'(MIN_GAP_MS);
    localparam logic [15:0] POLL_V    = 16'(POLL_MS);
    localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT_MS);
    localparam logic [7:0]  RETRY_V   = 8'(MAX_RETRY);

    typedef enum logic [2:0] {IDLE, GAP, START, WAIT, DONE} state_t;
    state_t state_q, state_d;

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [15:0] gap_ms_q, gap_ms_d;
    logic [15:0] poll_ms_q, poll_ms_d;
    logic [15:0] to_ms_q, to_ms_d;
    logic        poll_due_q, poll_due_d;
    logic        first_q, first_d;
    logic [7:0]  retry_q, retry_d;
    logic [1:0]  snap_q, snap_d;
    logic        failed_q, failed_d;
    logic [15:0] humi_q, humi_d;
    logic [15:0] temp_q, temp_d;
    logic        valid_q, valid_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic       ms_tick, gap_met, timeout, pending, csum_ok;
    logic [7:0] csum_calc;

    assign ms_tick   = (tick_cnt_q == TICK_LAST);
    assign csum_calc = rd_data[39:32] + rd_data[31:24] + rd_data[23:16] + rd_data[15:8];
    assign csum_ok   = (csum_calc == rd_data[7:0]);
    assign pending   = (|req) | poll_due_q;
    // The power-up wait applies only until the first attempt after reset.
    assign gap_met   = first_q ? (gap_ms_q >= POWERUP_V) : (gap_ms_q >= MIN_GAP_V);
    assign timeout   = (state_q == WAIT) && ms_tick && (to_ms_q == TIMEOUT_V - 16'd1);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = ms_tick ? '0 : tick_cnt_q + 1'b1;
        gap_ms_d   = (ms_tick && gap_ms_q != '1) ? gap_ms_q + 16'd1 : gap_ms_q;
        to_ms_d    = (ms_tick && state_q == WAIT) ? to_ms_q + 16'd1 : to_ms_q;
        first_d    = first_q;
        retry_d    = retry_q;
        snap_d     = snap_q;
        failed_d   = failed_q;
        humi_d     = humi_q;
        temp_d     = temp_q;
        valid_d    = valid_q;
        err_cnt_d  = err_cnt_q;
        rd_start   = 1'b0;
        ack        = '0;
        fail       = 1'b0;

        if (!poll_en)
            poll_ms_d = '0;
        else if (ms_tick && poll_ms_q < POLL_V)
            poll_ms_d = poll_ms_q + 16'd1;
        else
            poll_ms_d = poll_ms_q;

        unique case (state_q)
            IDLE: if (pending) state_d = GAP;
            GAP:  if (gap_met) state_d = START;
            START: begin
                rd_start  = 1'b1;
                snap_d    = req;
                first_d   = 1'b0;
                to_ms_d   = '0;
                poll_ms_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (rd_done && !rd_err && csum_ok) begin
                    humi_d   = rd_data[39:24];
                    temp_d   = rd_data[23:8];
                    valid_d  = 1'b1;
                    gap_ms_d = '0;
                    state_d  = DONE;
                end else if (rd_done || timeout) begin
                    err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 8'd1;
                    gap_ms_d  = '0;
                    if (retry_q < RETRY_V) begin
                        retry_d = retry_q + 8'd1;
                        state_d = GAP;
                    end else begin
                        failed_d = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                ack      = snap_q & req;
                fail     = failed_q;
                retry_d  = '0;
                failed_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        poll_due_d = poll_en && !rd_start && (poll_due_q || poll_ms_d >= POLL_V);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            gap_ms_q   <= '0;
            poll_ms_q  <= '0;
            to_ms_q    <= '0;
            poll_due_q <= 1'b0;
            first_q    <= 1'b1;
            retry_q    <= '0;
            snap_q     <= '0;
            failed_q   <= 1'b0;
            humi_q     <= '0;
            temp_q     <= '0;
            valid_q    <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            gap_ms_q   <= gap_ms_d;
            poll_ms_q  <= poll_ms_d;
            to_ms_q    <= to_ms_d;
            poll_due_q <= poll_due_d;
            first_q    <= first_d;
            retry_q    <= retry_d;
            snap_q     <= snap_d;
            failed_q   <= failed_d;
            humi_q     <= humi_d;
            temp_q     <= temp_d;
            valid_q    <= valid_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign humi       = humi_q;
    assign temp       = temp_q;
    assign data_valid = valid_q;
    assign err_cnt    = err_cnt_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dht11_sched.sv
// Randomized bench for dht11_sched: a cycle-time model of ms ticks, gaps, polls and
// timeouts predicts every rd_start cycle and the DONE-cycle results.
module tb_dht11_sched;
    localparam int CLK_FREQ   = 4000;
    localparam int POWERUP_MS = 10;
    localparam int MIN_GAP_MS = 20;
    localparam int POLL_MS    = 50;
    localparam int TIMEOUT_MS = 5;
    localparam int MAX_RETRY  = 2;
    localparam int DIV        = CLK_FREQ / 1000;

    localparam int M_GOOD = 0, M_BADSUM = 1, M_RDERR = 2, M_SILENT = 3, M_LATE = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst, poll_en, rd_done, rd_err;
    logic [1:0]  req, ack;
    logic        rd_start, data_valid, fail, busy;
    logic [39:0] rd_data;
    logic [15:0] humi, temp;
    logic [7:0]  err_cnt;

    dht11_sched #(
        .CLK_FREQ(CLK_FREQ), .POWERUP_MS(POWERUP_MS), .MIN_GAP_MS(MIN_GAP_MS),
        .POLL_MS(POLL_MS), .TIMEOUT_MS(TIMEOUT_MS), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .poll_en(poll_en), .req(req), .ack(ack),
        .rd_start(rd_start), .rd_done(rd_done), .rd_err(rd_err), .rd_data(rd_data),
        .humi(humi), .temp(temp), .data_valid(data_valid), .fail(fail),
        .err_cnt(err_cnt), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    int rel = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit          m_first;
    int          m_gap_base, poll_base, m_err;
    logic [15:0] m_humi, m_temp;
    bit          m_valid;
    int          modes[$];
    logic [39:0] frames[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int now();
        return cyc - rel;
    endfunction

    // Cycle index of the n-th ms tick at or after cycle base (ticks on c % DIV == DIV-1).
    function automatic int nth_tick(input int base, input int n);
        int c0;
        c0 = base + (DIV - 1 - (base % DIV));
        return c0 + DIV * (n - 1);
    endfunction

    function automatic logic [39:0] make_frame(input logic [31:0] body, input bit good);
        logic [7:0] s;
        s = body[31:24] + body[23:16] + body[15:8] + body[7:0];
        if (!good) s = s + 8'd1;
        return {body, s};
    endfunction

    task automatic do_reset(input logic pe);
        sys_rst = 1'b1;
        req = '0;
        rd_done = 1'b0;
        rd_err = 1'b0;
        repeat (2) @(negedge sys_clk);
        poll_en = pe;
        sys_rst = 1'b0;
        rel = cyc;
        m_first = 1'b1;
        m_gap_base = 0;
        poll_base = 0;
        m_err = 0;
        m_humi = '0;
        m_temp = '0;
        m_valid = 1'b0;
    endtask

    task automatic wait_start(input int limit, output int at);
        at = -1;
        for (int n = 0; n < limit && at < 0; n++) begin
            @(negedge sys_clk);
            if (rd_start) at = now();
        end
    endtask

    // One transaction, possibly with retries; engine behaviour per attempt comes from modes.
    task automatic run_txn(input int min_start, input logic [1:0] drop,
                           input logic [1:0] raise, input logic [1:0] exp_ack);
        int s, d, exp_s, mode, t_out;
        logic [39:0] f;
        bit good;
        for (int a = 0; a <= MAX_RETRY; a++) begin
            exp_s = nth_tick(m_gap_base, m_first ? POWERUP_MS : MIN_GAP_MS) + 2;
            if (a == 0 && min_start > exp_s) exp_s = min_start;
            wait_start(exp_s - now() + 40, s);
            check_val("start_cycle", 64'(s), 64'(exp_s));
            if (s < 0) return;
            check_val("busy_start", 64'(busy), 64'(1));
            m_first = 1'b0;
            if (poll_en) poll_base = s + 1;
            mode = (modes.size() != 0) ? modes.pop_front() : M_GOOD;
            t_out = nth_tick(s + 1, TIMEOUT_MS);
            d = (mode == M_SILENT || mode == M_LATE) ? t_out : s + int'($urandom_range(1, 12));
            f = (frames.size() != 0) ? frames.pop_front() : make_frame($urandom, mode != M_BADSUM);
            good = (mode == M_GOOD || mode == M_LATE);
            while (now() < d) begin
                @(negedge sys_clk);
                if (a == 0 && now() == s + 1) req = (req & ~drop) | raise;
            end
            if (mode != M_SILENT) begin
                rd_done = 1'b1;
                rd_err = (mode == M_RDERR);
                rd_data = f;
            end
            @(negedge sys_clk);
            rd_done = 1'b0;
            rd_err = 1'b0;
            if (good) begin
                m_humi = f[39:24];
                m_temp = f[23:8];
                m_valid = 1'b1;
            end else begin
                m_err = (m_err >= 255) ? 255 : m_err + 1;
            end
            m_gap_base = d + 1;
            check_val("err_cnt", 64'(err_cnt), 64'(m_err));
            if (good || a == MAX_RETRY) begin
                check_val("ack", 64'(ack), 64'(exp_ack));
                check_val("fail", 64'(fail), 64'(!good));
                check_val("humi", 64'(humi), 64'(m_humi));
                check_val("temp", 64'(temp), 64'(m_temp));
                check_val("data_valid", 64'(data_valid), 64'(m_valid));
                req = req & ~exp_ack;
                @(negedge sys_clk);
                check_val("busy_end", 64'(busy), 64'(0));
                return;
            end
            check_val("retry_outs", 64'({ack, fail, busy}), 64'(4'b0001));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int i, s, r;
        logic [1:0] dm;
        sys_rst = 1'b1; poll_en = 1'b0; req = '0; rd_done = 1'b0; rd_err = 1'b0; rd_data = '0;

        // Power-up read with a fixed frame
        do_reset(1'b0);
        check_val("reset_outs", 64'({ack, rd_start, humi, temp, data_valid, fail, err_cnt, busy}), 64'(0));
        req = 2'b01;
        frames.push_back(40'h35_00_18_00_4D);
        modes.push_back(M_GOOD);
        run_txn(now() + 2, 2'b00, 2'b00, 2'b01);
        check_val("humi_fixed", 64'(humi), 64'(16'h3500));
        check_val("temp_fixed", 64'(temp), 64'(16'h1800));

        // Bad checksum, then good retry
        req = 2'b10;
        frames.push_back(40'h35_00_18_00_4C);
        modes.push_back(M_BADSUM);
        modes.push_back(M_GOOD);
        run_txn(now() + 2, 2'b00, 2'b00, 2'b10);

        // Engine silent on every attempt
        req = 2'b10;
        repeat (MAX_RETRY + 1) modes.push_back(M_SILENT);
        run_txn(now() + 2, 2'b00, 2'b00, 2'b10);

        // req[1] leaves and req[0] joins during GAP, req[1] returns during WAIT
        i = now();
        req = 2'b10;
        repeat (5) @(negedge sys_clk);
        rd_done = 1'b1; rd_err = 1'b1;
        @(negedge sys_clk);
        rd_done = 1'b0; rd_err = 1'b0;
        repeat (4) @(negedge sys_clk);
        req = 2'b11;
        repeat (10) @(negedge sys_clk);
        req = 2'b01;
        modes.push_back(M_GOOD);
        run_txn(i + 2, 2'b00, 2'b10, 2'b01);
        modes.push_back(M_GOOD);
        run_txn(now() + 2, 2'b00, 2'b00, 2'b10);

        // Random requesters, engine behaviours and requester drops
        for (int n = 0; n < 8; n++) begin
            r = int'($urandom_range(1, 3));
            req = r[1:0];
            for (int a = 0; a <= MAX_RETRY; a++) begin
                case ($urandom_range(0, 9))
                    6: modes.push_back(M_BADSUM);
                    7: modes.push_back(M_RDERR);
                    8: modes.push_back(M_SILENT);
                    9: modes.push_back(M_LATE);
                    default: modes.push_back(M_GOOD);
                endcase
            end
            dm = ($urandom_range(0, 2) == 0) ? (r[1:0] & 2'($urandom_range(1, 3))) : 2'b00;
            run_txn(now() + 2, dm, 2'b00, r[1:0] & ~dm);
            modes.delete();
        end

        // Reset in the middle of WAIT
        req = 2'b01;
        i = now();
        wait_start(200, s);
        check_val("pre_reset_start", 64'(s), 64'(nth_tick(m_gap_base, MIN_GAP_MS) + 2));
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        check_val("rst_outs", 64'({ack, rd_start, humi, temp, data_valid, fail, err_cnt, busy}), 64'(0));
        do_reset(1'b0);
        repeat (2) @(negedge sys_clk);
        rd_done = 1'b1; rd_data = make_frame($urandom, 1'b1);
        @(negedge sys_clk);
        rd_done = 1'b0;
        check_val("late_done_ignored", 64'({data_valid, err_cnt, busy, humi}), 64'(0));
        req = 2'b01;
        modes.push_back(M_GOOD);
        run_txn(now() + 2, 2'b00, 2'b00, 2'b01);

        // Periodic polling without requesters
        do_reset(1'b1);
        for (int n = 0; n < 3; n++) begin
            modes.push_back(M_GOOD);
            run_txn(nth_tick(poll_base, POLL_MS) + 3, 2'b00, 2'b00, 2'b00);
        end
        poll_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
